// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store initiator between the MEM stage and a word-wide
//                dmem. Byte and halfword loads are sign- or zero-extended.
//                Sub-word stores use a read-modify-write sequence.
//                Optional macro LSU_ALIGN_CHECK_EN enables misalignment and
//                reserved-size detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int AW = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RMW   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_wdata;

    logic        w_err;
    logic [1:0]  w_size;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_unused;

    // Byte-address bits above the dmem window are ignored.
    assign w_unused = ^req_addr[31:AW+2];

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        w_err  = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
        w_size = req_size;
        w_lane = req_addr[1:0];
    end
`else
    // Without checking, the reserved size acts as a word and low address
    // bits are forced to the natural alignment of the access.
    always_comb begin
        w_err  = 1'b0;
        w_size = (req_size == 2'b11) ? 2'b10 : req_size;
        case (w_size)
            2'b00:   w_lane = req_addr[1:0];
            2'b01:   w_lane = {req_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end
`endif

    always_comb begin
        w_byte = mem_rd[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_rd;
        endcase
    end

    always_comb begin
        w_merge = mem_rd;
        if (r_size == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_lane[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP) & ~reset;
    assign mem_we     = (r_state == S_WRITE) & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_wdata    <= 16'h0000;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_lane   <= w_lane;
                        r_size   <= w_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata[15:0];
                        if (w_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0000_0000;
                            r_state    <= S_RESP;
                        end else begin
                            mem_addr <= req_addr[AW+1:2];
                            if (!req_we) begin
                                r_state <= S_LOAD;
                            end else if (w_size == 2'b10) begin
                                mem_wd  <= req_wdata;
                                r_state <= S_WRITE;
                            end else begin
                                r_state <= S_RMW;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata <= w_load;
                    resp_err   <= 1'b0;
                    r_state    <= S_RESP;
                end
                S_RMW: begin
                    mem_wd  <= w_merge;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    resp_rdata <= 32'h0000_0000;
                    resp_err   <= 1'b0;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
